riscv_imem_loader: RTL

Sits directly downstream of the host register file's RISC-V instruction-memory write port. It turns the level-held `host_write` / `host_waitrequest` handshake into single-cycle writes to the RISC-V instruction SRAM. It also arbitrates that SRAM's single port between host loading and RISC-V core instruction fetch, using `host_select`. It tracks successful loads and rejected (misaligned or out-of-range) writes for software.

---
 rtl/riscv_imem_loader.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/riscv_imem_loader.sv
// riscv_imem_loader: turns the host's level-held write handshake into single-cycle SRAM
// writes, and shares the single SRAM port between host loading and core instruction fetch.
module riscv_imem_loader #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           host_address,
    input  logic [31:0]           host_writedata,
    input  logic                  host_write,
    output logic                  host_waitrequest,
    input  logic                  host_select,
    input  logic [31:0]           core_address,
    input  logic                  core_read,
    output logic                  core_waitrequest,
    output logic [31:0]           core_readdata,
    output logic                  core_readdatavalid,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    output logic                  ram_we,
    output logic                  ram_re,
    input  logic [31:0]           ram_rdata,
    output logic [15:0]           load_count,
    output logic [15:0]           err_count,
    output logic [31:0]           err_last_addr
);

    typedef enum logic [1:0] {StIdle, StHwrite, StHdone} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        sel_q;
    logic [15:0] load_count_q;
    logic [15:0] err_count_q;
    logic [31:0] err_last_addr_q;
    logic        rvalid_q;
    logic        rnop_q;

    logic host_valid;
    logic core_in_range;
    logic core_accept;
    logic sel_rise;
    logic unused_core_lsb;

    // Word-aligned and inside the 4*2^ADDR_WIDTH byte window.
    assign host_valid    = (addr_q[1:0] == 2'b00) && ((addr_q >> (ADDR_WIDTH + 2)) == 32'd0);
    assign core_in_range = ((core_address >> (ADDR_WIDTH + 2)) == 32'd0);

    assign core_waitrequest = host_select | (state_q != StIdle);
    assign core_accept      = core_read & ~core_waitrequest;
    assign sel_rise         = host_select & ~sel_q;
    // Byte offset within the fetched word is irrelevant.
    assign unused_core_lsb  = ^core_address[1:0];

    assign host_waitrequest   = (state_q != StHdone);
    assign core_readdatavalid = rvalid_q;
    assign load_count         = load_count_q;
    assign err_count          = err_count_q;
    assign err_last_addr      = err_last_addr_q;

    // Host FSM next state; a write is latched only while the host owns the port.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (host_write && host_select) begin
                    state_d = StHwrite;
                    addr_d  = host_address;
                    data_d  = host_writedata;
                end
            end
            StHwrite: state_d = StHdone;
            StHdone:  state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // SRAM port mux: host write in HWRITE, otherwise an accepted in-range core fetch.
    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (state_q == StHwrite) begin
            if (host_valid) begin
                ram_we    = 1'b1;
                ram_addr  = addr_q[ADDR_WIDTH+1:2];
                ram_wdata = data_q;
            end
        end else if (core_accept && core_in_range) begin
            ram_re   = 1'b1;
            ram_addr = core_address[ADDR_WIDTH+1:2];
        end
    end

    // Read data comes straight from the SRAM output register, or NOP for out-of-range fetches.
    always_comb begin
        core_readdata = '0;
        if (rvalid_q) begin
            core_readdata = rnop_q ? NOP_WORD : ram_rdata;
        end
    end

    // State, latched write, fetch-return flags and software-visible counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            addr_q          <= '0;
            data_q          <= '0;
            sel_q           <= 1'b0;
            rvalid_q        <= 1'b0;
            rnop_q          <= 1'b0;
            load_count_q    <= '0;
            err_count_q     <= '0;
            err_last_addr_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            sel_q    <= host_select;
            rvalid_q <= core_accept;
            rnop_q   <= core_accept & ~core_in_range;
            // Clear on select rising beats a coincident increment.
            if (sel_rise) begin
                load_count_q <= '0;
            end else if ((state_q == StHwrite) && host_valid) begin
                load_count_q <= load_count_q + 16'd1;
            end
            if ((state_q == StHwrite) && !host_valid) begin
                err_last_addr_q <= addr_q;
                if (err_count_q != 16'hFFFF) begin
                    err_count_q <= err_count_q + 16'd1;
                end
            end
        end
    end

endmodule
